// File: rtl/norm_pkg.sv
// rtl/norm_pkg.sv - shared width helpers, FSM states and saturation limit for the layer-norm stages
package norm_pkg;

  localparam int DEF_IL = 4;
  localparam int DEF_FL = 16;

  function automatic int calc_w(input int il, input int fl);
    return il + fl;
  endfunction

  function automatic int calc_acc_w(input int il, input int fl);
    return 2 * (il + fl) + 4;
  endfunction

  function automatic longint unsigned max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  localparam longint unsigned MAX_POS = max_pos(calc_w(DEF_IL, DEF_FL));

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_e;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, one quotient bit per cycle, MSB first
module seq_divider #(
  parameter int DW = 44
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] dividend,
  input  logic [3:0]    divisor,
  output logic [DW-1:0] quotient,
  output logic          ready
);
  localparam int CW = $clog2(DW);

  logic [DW-1:0] quot_q, quot_d, src_quot;
  logic [3:0]    rem_q, rem_d, dsr_q, dsr_d, src_rem, src_dsr, step_rem;
  logic [4:0]    trial;
  logic          step_bit;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  // The load cycle already retires the first quotient bit, so DW bits finish DW-1 cycles later.
  always_comb begin
    src_rem  = load ? 4'd0 : rem_q;
    src_quot = load ? dividend : quot_q;
    src_dsr  = load ? divisor : dsr_q;
    trial    = {src_rem, src_quot[DW-1]};
    step_bit = (trial >= {1'b0, src_dsr});
    step_rem = step_bit ? 4'(trial - {1'b0, src_dsr}) : trial[3:0];

    rem_d   = rem_q;
    quot_d  = quot_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (load) begin
      rem_d   = step_rem;
      quot_d  = {src_quot[DW-2:0], step_bit};
      dsr_d   = divisor;
      cnt_d   = CW'(DW - 1);
      ready_d = 1'b0;
    end else if (cnt_q != '0) begin
      rem_d   = step_rem;
      quot_d  = {src_quot[DW-2:0], step_bit};
      cnt_d   = cnt_q - 1'b1;
      ready_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quot_q  <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign quotient = quot_q;
  assign ready    = ready_q;

endmodule

// File: rtl/variance_seq.sv
// rtl/variance_seq.sv - population variance of a batch vector: one element per cycle, then a serial divide
module variance_seq
  import norm_pkg::*;
#(
  parameter int IL   = DEF_IL,
  parameter int FL   = DEF_FL,
  parameter int size = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [size-1:0][IL+FL-1:0] batch,
  input  logic [IL+FL-1:0]           mean_in,
  input  logic [3:0]                 num,
  output logic [IL+FL-1:0]           var_out,
  output logic                       busy,
  output logic                       done
);
  localparam int W     = calc_w(IL, FL);
  localparam int ACC_W = calc_acc_w(IL, FL);
  // MAX_POS covers the datapath format; any other format derives its own limit.
  localparam logic [ACC_W-1:0] SAT = (W == calc_w(DEF_IL, DEF_FL)) ? ACC_W'(MAX_POS)
                                                                    : ACC_W'(max_pos(W));

  state_e                    state_q, state_d;
  logic [size-1:0][W-1:0]    batch_q, batch_d;
  logic [W-1:0]              mean_q, mean_d, var_q, var_d;
  logic [3:0]                num_q, num_d, idx_q, idx_d;
  logic [ACC_W-1:0]          acc_q, acc_d, sq_acc, quot;
  logic                      done_q, done_d, busy_q, busy_d;
  logic                      div_load, div_ready;
  logic [W:0]                diff;
  logic signed [2*W+1:0]     diff_x;
  logic [2*W+1:0]            sq;

  always_comb begin
    diff   = {batch_q[idx_q][W-1], batch_q[idx_q]} - {mean_q[W-1], mean_q};
    diff_x = {{(W+1){diff[W]}}, diff};
    sq     = diff_x * diff_x;
    sq_acc = ACC_W'(sq >> FL);

    state_d  = state_q;
    batch_d  = batch_q;
    mean_d   = mean_q;
    num_d    = num_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    var_d    = var_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        batch_d = batch;
        mean_d  = mean_in;
        num_d   = num;
        acc_d   = '0;
        idx_d   = '0;
        state_d = (num == 4'd0) ? DONE : ACCUM;
      end
      ACCUM: begin
        acc_d = acc_q + sq_acc;
        idx_d = idx_q + 4'd1;
        if (idx_q == num_q - 4'd1) begin
          state_d  = DIVIDE;
          div_load = 1'b1;
        end
      end
      DIVIDE: if (div_ready) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (num_q == 4'd0) var_d = '0;
        else               var_d = (quot > SAT) ? SAT[W-1:0] : quot[W-1:0];
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      batch_q <= '0;
      mean_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      var_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      batch_q <= batch_d;
      mean_q  <= mean_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      var_q   <= var_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  seq_divider #(.DW(ACC_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .dividend (acc_d),
    .divisor  (num_q),
    .quotient (quot),
    .ready    (div_ready)
  );

  assign var_out = var_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_variance_seq.sv
// tb/tb_variance_seq.sv - bench for variance_seq against a timeline/arithmetic model
module tb_variance_seq;
  localparam int W     = 20;
  localparam int ACC_W = 44;
  localparam int N     = 16;
  typedef logic [N-1:0][W-1:0] vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  vec_t         batch = '0;
  logic [W-1:0] mean_in = '0;
  logic [3:0]   num = '0;
  logic [W-1:0] var_out;
  logic         busy, done;

  int total = 0;
  int bad   = 0;

  variance_seq #(.IL(4), .FL(16), .size(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .batch   (batch),
    .mean_in (mean_in),
    .num     (num),
    .var_out (var_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_var(input vec_t b, input logic [W-1:0] m, input int n);
    longint acc, d, q;
    acc = 0;
    if (n == 0) return '0;
    for (int i = 0; i < n; i++) begin
      d = longint'($signed(b[i])) - longint'($signed(m));
      acc += (d * d) >> 16;
    end
    q = acc / n;
    return (q > 64'h7FFFF) ? 20'h7FFFF : 20'(q);
  endfunction

  function automatic vec_t rand_batch();
    vec_t b;
    for (int i = 0; i < N; i++) b[i] = W'($urandom);
    return b;
  endfunction

  function automatic vec_t fill4(input logic [W-1:0] a, input logic [W-1:0] b2,
                                 input logic [W-1:0] c, input logic [W-1:0] d);
    vec_t v;
    v = '0;
    v[0] = a; v[1] = b2; v[2] = c; v[3] = d;
    return v;
  endfunction

  // Model: each accepted request completes at a fixed edge; outputs follow from that timeline.
  int           cyc = 0;
  int           done_edge = 0;
  bit           m_active = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [W-1:0] m_var = '0, m_pending = '0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_var    = '0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (cyc == done_edge) begin
          m_done   = 1'b1;
          m_var    = m_pending;
          m_active = 1'b0;
        end
      end else if (start) begin
        m_active  = 1'b1;
        done_edge = cyc + ((num == 4'd0) ? 1 : int'(num) + ACC_W + 1);
        m_pending = model_var(batch, mean_in, int'(num));
      end
    end
    m_busy = m_active;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      total++;
      if ({busy, done, var_out} !== {m_busy, m_done, m_var}) begin
        bad++;
        $display("FAIL cycle_check cyc=%0d got busy=%b done=%b var=%h want busy=%b done=%b var=%h",
                 cyc, busy, done, var_out, m_busy, m_done, m_var);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic launch(input vec_t b, input logic [W-1:0] m, input logic [3:0] n);
    batch   = b;
    mean_in = m;
    num     = n;
    start   = 1'b1;
  endtask

  // Returns k such that done is seen in the cycle after edge k (edge 0 samples start).
  task automatic wait_done(output int k, input bit poke);
    k = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      start = poke && (k == 2 || k == 20);
      if (k == 0 || start) begin
        batch   = rand_batch();
        mean_in = W'($urandom);
        num     = 4'($urandom_range(1, 15));
      end
      if (done === 1'b1) break;
      k++;
      if (k > 200) begin
        total++;
        bad++;
        $display("FAIL done_timeout got=no_done want=done_within_200");
        k = -1;
        break;
      end
    end
  endtask

  vec_t const_b, alt_b, sat_b, tri_b;
  int   lat, seen, n_r;

  initial begin
    for (int i = 0; i < N; i++) const_b[i] = 20'h10000;
    alt_b = fill4(20'h10000, 20'hF0000, 20'h10000, 20'hF0000);
    sat_b = fill4(20'h7FFFF, 20'h80000, 20'h0, 20'h0);
    tri_b = fill4(20'h20000, 20'h0, 20'h0, 20'h0);

    check("model_const", 64'(model_var(const_b, 20'h10000, 4)), 64'h0);
    check("model_alt",   64'(model_var(alt_b, 20'h0, 4)), 64'h10000);
    check("model_sat",   64'(model_var(sat_b, 20'h0, 2)), 64'h7FFFF);
    check("model_trunc", 64'(model_var(tri_b, 20'h0, 3)), 64'h15555);

    // Reset with start held high: reset must win.
    batch = rand_batch(); num = 4'd4; start = 1'b1; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_var",  64'(var_out), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'h0);

    launch(const_b, 20'h10000, 4'd4);
    wait_done(lat, 1'b0);
    check("const_lat", 64'(lat), 64'd49);
    check("const_var", 64'(var_out), 64'h0);

    launch(alt_b, 20'h0, 4'd4);
    wait_done(lat, 1'b0);
    check("alt_lat", 64'(lat), 64'd49);
    check("alt_var", 64'(var_out), 64'h10000);
    @(negedge clk);
    check("alt_done_width", 64'(done), 64'h0);
    check("alt_var_hold", 64'(var_out), 64'h10000);

    launch(sat_b, 20'h0, 4'd2);
    wait_done(lat, 1'b0);
    check("sat_lat", 64'(lat), 64'd47);
    check("sat_var", 64'(var_out), 64'h7FFFF);

    launch(tri_b, 20'h0, 4'd3);
    wait_done(lat, 1'b0);
    check("trunc_var", 64'(var_out), 64'h15555);

    launch(rand_batch(), W'($urandom), 4'd0);
    wait_done(lat, 1'b0);
    check("zero_lat", 64'(lat), 64'd1);
    check("zero_var", 64'(var_out), 64'h0);
    @(negedge clk);
    check("zero_busy_after", 64'(busy), 64'h0);

    // Starts during ACCUM and DIVIDE are ignored; a start in the done cycle is accepted.
    launch(alt_b, 20'h0, 4'd4);
    wait_done(lat, 1'b1);
    check("poke_lat", 64'(lat), 64'd49);
    check("poke_var", 64'(var_out), 64'h10000);
    launch(sat_b, 20'h0, 4'd2);
    wait_done(lat, 1'b0);
    check("chain_lat", 64'(lat), 64'd47);
    check("chain_var", 64'(var_out), 64'h7FFFF);

    // Abort during DIVIDE.
    launch(alt_b, 20'h0, 4'd4);
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_var",  64'(var_out), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    launch(alt_b, 20'h0, 4'd4);
    wait_done(lat, 1'b0);
    check("after_abort_lat", 64'(lat), 64'd49);
    check("after_abort_var", 64'(var_out), 64'h10000);

    for (int t = 0; t < 25; t++) begin
      n_r = $urandom_range(0, 15);
      launch(rand_batch(), W'($urandom), 4'(n_r));
      wait_done(lat, 1'($urandom_range(0, 1)));
      check("rand_lat", 64'(lat), 64'((n_r == 0) ? 1 : n_r + ACC_W + 1));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
